// File: rtl/siso_lr_framed_if.sv
// Bus bundle for the left-to-right framed SISO shift register.
// Groups the control, data and status signals of one register instance.
interface siso_lr_framed_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Qualifier semantics: there is no backpressure. en and load are sampled
    // on every rising edge. so_valid qualifies so while it is high. word_done
    // qualifies q as a complete word for exactly the one cycle it is high.
    logic             en;
    logic             si;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             so;
    logic [WIDTH-1:0] q;
    logic             so_valid;
    logic             word_done;
    logic [CNT_W-1:0] fill;

    modport master (
        output en, si, load, din,
        input  so, q, so_valid, word_done, fill
    );

    modport slave (
        input  en, si, load, din,
        output so, q, so_valid, word_done, fill
    );
endinterface

// File: rtl/siso_lr_framed.sv
// Left-to-right serial-in serial-out shift register: si enters at q[0], so leaves from q[WIDTH-1].
// Adds a parallel preload, fill tracking and a one-cycle word-boundary pulse.
module siso_lr_framed #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            clear_n,
    siso_lr_framed_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             word_done_q, word_done_d;

    // Priority is load over en over hold; si and din are only looked at on the selected path.
    always_comb begin
        q_d         = q_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = 1'b0;
        if (bus.load) begin
            q_d       = bus.din;
            fill_d    = CNT_W'(WIDTH);
            bit_cnt_d = '0;
        end else if (bus.en) begin
            q_d = {q_q[WIDTH-2:0], bus.si};
            if (fill_q != CNT_W'(WIDTH)) begin
                fill_d = fill_q + CNT_W'(1);
            end
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                bit_cnt_d   = '0;
                word_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q         <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.so        = q_q[WIDTH-1];
    assign bus.fill      = fill_q;
    assign bus.so_valid  = (fill_q == CNT_W'(WIDTH));
    assign bus.word_done = word_done_q;
endmodule

// File: tb/tb_siso_lr_framed.sv
// Scoreboard bench for siso_lr_framed: a bit-queue reference model predicts every
// post-edge state, and a negedge monitor pops and compares those predictions.
module tb_siso_lr_framed;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int EW    = WIDTH + CNT_W + 3;

    logic clk = 1'b0;
    logic clear_n = 1'b0;

    siso_lr_framed_if #(.WIDTH(WIDTH)) bus ();

    siso_lr_framed #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: the register is a queue of bits, oldest (next out) at the front.
    logic m_bits[$];
    int   m_fill;
    int   m_shifts;
    logic m_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] model_pack();
        logic [WIDTH-1:0] mq;
        for (int i = 0; i < WIDTH; i++) mq[WIDTH-1-i] = m_bits[i];
        return {mq, m_bits[0], (m_fill == WIDTH), m_wd, CNT_W'(m_fill)};
    endfunction

    task automatic model_reset();
        m_bits = {};
        for (int i = 0; i < WIDTH; i++) m_bits.push_back(1'b0);
        m_fill   = 0;
        m_shifts = 0;
        m_wd     = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic s, input logic l, input logic [WIDTH-1:0] d);
        if (!clear_n) begin
            model_reset();
            return;
        end
        m_wd = 1'b0;
        if (l) begin
            m_bits = {};
            for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(d[i]);
            m_fill   = WIDTH;
            m_shifts = 0;
        end else if (e) begin
            m_bits.push_back(s);
            void'(m_bits.pop_front());
            if (m_fill < WIDTH) m_fill++;
            m_shifts++;
            if (m_shifts == WIDTH) begin
                m_wd     = 1'b1;
                m_shifts = 0;
            end
        end
    endtask

    task automatic cmp_all(input logic [EW-1:0] e, input string tag);
        check({tag, "_q"},         32'(bus.q),         32'(e[EW-1 -: WIDTH]));
        check({tag, "_so"},        32'(bus.so),        32'(e[CNT_W+2]));
        check({tag, "_so_valid"},  32'(bus.so_valid),  32'(e[CNT_W+1]));
        check({tag, "_word_done"}, 32'(bus.word_done), 32'(e[CNT_W]));
        check({tag, "_fill"},      32'(bus.fill),      32'(e[CNT_W-1:0]));
        check({tag, "_no_x"},
              32'($isunknown({bus.q, bus.so, bus.so_valid, bus.word_done, bus.fill})), 32'd0);
    endtask

    // Monitor: every rising edge pushes one prediction; it is checked at the following falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) cmp_all(exp_q.pop_front(), "mon");
    end

    task automatic step(input logic e, input logic s, input logic l, input logic [WIDTH-1:0] d);
        bus.en   = e;
        bus.si   = s;
        bus.load = l;
        bus.din  = d;
        @(posedge clk);
        model_edge(e, s, l, d);
        exp_q.push_back(model_pack());
        @(negedge clk);
    endtask

    task automatic async_reset_check(input string tag);
        #2 clear_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_q"},        32'(bus.q),        32'd0);
        check({tag, "_fill"},     32'(bus.fill),     32'd0);
        check({tag, "_so_valid"}, 32'(bus.so_valid), 32'd0);
    endtask

    logic [WIDTH-1:0] t1_q [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    logic             t1_si[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic             t4_so[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        bus.en = 1'b0; bus.si = 1'b0; bus.load = 1'b0; bus.din = '0;
        model_reset();
        #3;
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_word_done", 32'(bus.word_done), 32'd0);
        step(1'b1, 1'b1, 1'b0, '0);
        #1 clear_n = 1'b1;

        // Test 1: four enabled shifts from reset.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, t1_si[i], 1'b0, '0);
            check("t1_q", 32'(bus.q), 32'(t1_q[i]));
            check("t1_fill", 32'(bus.fill), 32'(i + 1));
            check("t1_wd", 32'(bus.word_done), 32'(i == 3));
        end
        check("t1_so", 32'(bus.so), 32'd1);

        // Test 2: continuous alternating stream, pulse every WIDTH edges.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, ((i % 2) == 0), 1'b0, '0);
            check("t2_wd", 32'(bus.word_done), 32'(i == 3 || i == 7));
            if (i == 3 || i == 7) check("t2_q", 32'(bus.q), 32'b1010);
        end

        // Test 3: shift 2, hold 3, shift 2.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '1);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("t3_q", 32'(bus.q), 32'b0110);
        check("t3_wd", 32'(bus.word_done), 32'd1);

        // Test 4: load mid-word, then five zero shifts.
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 4'b1001);
        check("t4_q", 32'(bus.q), 32'b1001);
        check("t4_so_load", 32'(bus.so), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            check("t4_so", 32'(bus.so), 32'(t4_so[i]));
            check("t4_wd", 32'(bus.word_done), 32'(i == 3));
        end

        // Test 5: async reset after 3 shifts, then a fresh word.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
        async_reset_check("t5_async");
        step(1'b1, 1'b1, 1'b0, '0);
        #1 clear_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            check("t5_wd", 32'(bus.word_done), 32'(i == 3));
        end

        // Test 6: unknown si/din while idle must not disturb anything.
        for (int i = 0; i < 4; i++) step(1'b0, 1'bx, 1'b0, 'x);

        // Random traffic with occasional loads and asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset_check("rnd_async");
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
                #1 clear_n = 1'b1;
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0), WIDTH'($urandom));
            end
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/siso_lr_framed.md
Name: siso_lr_framed

Overview:
Left-to-right serial-in serial-out shift register. Serial input enters at the LSB and serial output leaves from the MSB. It complements the team's right-to-left SISO, which takes input at the MSB and outputs at the LSB. The block adds shift-enable, parallel preload, fill tracking and a word-boundary pulse, so serial streams can be framed into WIDTH-bit words without external counters.

Parameters:
WIDTH, 4, register length in bits; legal range is WIDTH >= 2.
CNT_W (localparam, not overridable), $clog2(WIDTH+1), width of the fill and bit counters.

Ports:
clk  input  1  clock; all state updates on the rising edge.
clear_n  input  1  asynchronous, active-low reset.
en  input  1  shift enable; one shift per rising edge while high.
si  input  1  serial input, shifted into q[0].
load  input  1  parallel load strobe.
din  input  WIDTH  parallel load data.
so  output  1  serial output, equal to q[WIDTH-1] (combinational from q).
q  output  WIDTH  register contents.
so_valid  output  1  high when fill == WIDTH, i.e. so carries a bit that entered via si or load, not reset fill.
word_done  output  1  registered one-cycle pulse marking a completed WIDTH-bit word.
fill  output  CNT_W  count of valid bits held, 0..WIDTH.

Behaviour:
- Reset (clear_n low, async): takes effect immediately, independent of clk.
  - q=0, so=0, fill=0, so_valid=0, word_done=0, internal bit_cnt=0.
  - All state holds at reset values while clear_n is low.
  - The first edge after release is a normal operating edge.
- Priority per rising edge: load > en > hold.
- load=1 (en and si ignored):
  - q <= din; fill <= WIDTH; bit_cnt <= 0; word_done <= 0.
- load=0, en=1:
  - q <= {q[WIDTH-2:0], si}.
  - fill <= fill+1, saturating at WIDTH.
  - If bit_cnt == WIDTH-1: bit_cnt <= 0 and word_done <= 1. Otherwise bit_cnt <= bit_cnt+1 and word_done <= 0.
- load=0, en=0:
  - q, fill and bit_cnt hold; word_done <= 0.
- word_done timing:
  - It is high for exactly the one cycle after the edge that performed the WIDTH-th shift of a word.
  - In that cycle q holds the complete word, with the first-shifted bit at q[WIDTH-1].
  - Back-to-back words under continuous en produce a pulse every WIDTH cycles, with no gap cycle.
- Latency:
  - A bit sampled on si at an enabled edge appears at q[0] after that edge.
  - It reaches so after WIDTH-1 further enabled edges (WIDTH enabled edges total).
  - Disabled cycles stretch this latency but never drop or duplicate bits.
- fill and so_valid:
  - fill never wraps.
  - Once fill reaches WIDTH it stays there until reset.
  - so_valid is a combinational compare on the registered fill.
- Load mid-word: discards the partial bit_cnt. The next word_done requires WIDTH shifts counted from the load.
- Reset mid-word: discards everything. The next word_done requires WIDTH enabled shifts after release.
- No X propagation from din when load=0, or from si when en=0.

Test Plan:
1. WIDTH=4; reset; en=1 with si=1,0,1,1 on four edges -> q=0001, 0010, 0101, 1011; fill=1,2,3,4; so_valid rises with fill=4; word_done=1 only in the cycle after the 4th edge; so=1.
2. Continuous en for 8 edges with si alternating 1,0 -> word_done pulses after edges 4 and 8 only; q=1010 at both pulses.
3. Shift 2 bits, hold en=0 for 3 edges, shift 2 more -> q, fill and bit_cnt frozen during the hold; word_done after the 4th enabled edge; final q matches the 4-bit input order.
4. Shift 2 bits, then load=1, en=1, si=1, din=1001 -> q=1001, fill=4, so=1. Then 5 shifts with si=0 -> so=0,0,1,0,0; word_done after the 4th post-load shift, not at the earlier partial count.
5. After 3 shifts, pull clear_n low between edges -> q=0, fill=0, so_valid=0 immediately, without waiting for clk. After release, word_done appears only after 4 new enabled shifts.
6. load=0, en=0 with si and din driven X for 4 edges -> all outputs hold their previous known values; no X appears on any output.
